key_debounce: RTL

//   Debounces the board pushbuttons (raw, active-low, asynchronous) before they reach the

---
 rtl/key_debounce.sv | 107 ++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// key_debounce: synchronises raw active-low pushbuttons, qualifies each new level
// over STABLE_TICKS consecutive prescaler ticks and emits a clean level plus
// one-clock press/release strobes for the button PIO.

// Per-key qualifier: counts ticks while the synchronised input disagrees with
// the accepted level, and accepts the new level once the count completes.
module key_debounce_lane #(
    parameter int STABLE_TICKS = 20,
    parameter int CW           = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          sync_in,
    output logic          key_out,
    output logic          press_pulse,
    output logic          release_pulse,
    output logic [CW-1:0] cnt
);
    localparam logic [CW-1:0] CMAX = CW'(STABLE_TICKS - 1);

    // Any agreement clears the count, so bounce between ticks restarts qualification.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_out       <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            cnt           <= '0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (sync_in == key_out) begin
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CMAX) begin
                    key_out       <= sync_in;
                    cnt           <= '0;
                    press_pulse   <= ~sync_in;
                    release_pulse <= sync_in;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

module key_debounce #(
    parameter int NUM_KEYS     = 4,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_out,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic                busy
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    logic [NUM_KEYS-1:0]         sync1, sync2;
    logic [PW-1:0]               pcnt;
    logic                        tick;
    logic [NUM_KEYS-1:0][CW-1:0] cnt;

    // Two-flop synchroniser; released (1) level out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    assign tick = (pcnt == PMAX);

    // Free-running sample-tick prescaler, wraps on the tick cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     pcnt <= '0;
        else if (tick) pcnt <= '0;
        else           pcnt <= pcnt + PW'(1);
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
        key_debounce_lane #(
            .STABLE_TICKS(STABLE_TICKS),
            .CW          (CW)
        ) u_lane (
            .clk          (clk),
            .reset        (reset),
            .tick         (tick),
            .sync_in      (sync2[i]),
            .key_out      (key_out[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .cnt          (cnt[i])
        );
    end

    assign busy = |cnt;
endmodule
